// File: rtl/hamming_pkg.sv
// -----------------------------------------------------------------------------
// hamming_pkg
//   Shared types and constants for the SEC-DED Hamming(16,11) decode engine.
//   - state_t  : engine FSM states
//   - FLAG_*   : per-word decode status written into the output MSB [7:6]
//   - MSG_POS  : codeword bit position of each message bit (m[0] = cw[3])
//   - sat_inc8 : saturating 8-bit increment used by the statistics counters
// -----------------------------------------------------------------------------
package hamming_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_LO = 3'd1,
    RD_HI = 3'd2,
    DEC   = 3'd3,
    WR_LO = 3'd4,
    WR_HI = 3'd5,
    DONE  = 3'd6
  } state_t;

  localparam logic [1:0] FLAG_OK  = 2'b00;
  localparam logic [1:0] FLAG_COR = 2'b01;
  localparam logic [1:0] FLAG_DBL = 2'b10;

  localparam int CW_W  = 16;
  localparam int MSG_W = 11;

  // Non-power-of-two positions carry message bits; 0,1,2,4,8 are parity.
  localparam int MSG_POS [MSG_W] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// -----------------------------------------------------------------------------
// hamming_syndrome
//   Purely combinational SEC-DED Hamming(16,11) decoder for one codeword.
// Ports
//   i_cw   [15:0]  received codeword (p0 at bit 0, p1/p2/p4/p8 at bits 1/2/4/8)
//   o_msg  [10:0]  recovered message (corrected when a single error was seen)
//   o_flag [1:0]   FLAG_OK clean, FLAG_COR single error fixed, FLAG_DBL double
// -----------------------------------------------------------------------------
module hamming_syndrome
  import hamming_pkg::*;
(
  input  logic [15:0] i_cw,
  output logic [10:0] o_msg,
  output logic [1:0]  o_flag
);

  logic [3:0]  w_syn;
  logic        w_par;
  logic [15:0] w_fixed;

  // Syndrome is the XOR of the indices of all set bits; a valid codeword
  // yields zero, a single flip at position k yields k.
  always_comb begin
    w_syn = 4'd0;
    for (int k = 0; k < CW_W; k++) begin
      if (i_cw[k]) begin
        w_syn = w_syn ^ 4'(k);
      end
    end
  end

  assign w_par = ^i_cw;

  // Odd overall parity means an odd number of flips: assume one and repair
  // it. Syndrome 0 with odd parity points at p0 itself, which is harmless
  // to flip since p0 carries no message data.
  always_comb begin
    w_fixed = i_cw;
    if (w_par) begin
      w_fixed[w_syn] = ~i_cw[w_syn];
    end
  end

  generate
    for (genvar gi = 0; gi < MSG_W; gi++) begin : g_msg
      assign o_msg[gi] = w_fixed[MSG_POS[gi]];
    end
  endgenerate

  always_comb begin
    if (w_par) begin
      o_flag = FLAG_COR;
    end else if (w_syn != 4'd0) begin
      o_flag = FLAG_DBL;
    end else begin
      o_flag = FLAG_OK;
    end
  end

endmodule

// File: rtl/hamming_dec_engine.sv
// -----------------------------------------------------------------------------
// hamming_dec_engine
//   Memory-mapped SEC-DED Hamming(16,11) decode engine. On a request it reads
//   N_WORDS codewords (two bytes each) starting at IN_BASE, decodes them and
//   writes two message bytes per word starting at OUT_BASE.
//   Output LSB = m[7:0], MSB = {flag[1:0], 3'b000, m[10:8]}.
//
// Ports
//   i_clk            clock, rising edge
//   i_rst_n          asynchronous active-low reset
//   i_req            job request, sampled only in IDLE
//   o_done           job complete, held until i_req is low
//   o_busy           engine owns the memory port
//   o_mem_addr       read/write address (combinational from state and index)
//   i_mem_rd_data    read data, valid one cycle after o_mem_addr
//   o_mem_wr_en      write strobe
//   o_mem_wr_data    write data
//   o_err_cnt_corr   corrected-word count of the current/last job
//   o_err_cnt_dbl    uncorrectable-word count of the current/last job
//
// Build option
//   HAMMING_STATS_EN : when defined, the two error counters are implemented
//                      (saturating, cleared at job start). When undefined the
//                      counter ports are tied to 8'h00.
// -----------------------------------------------------------------------------
module hamming_dec_engine
  import hamming_pkg::*;
#(
  parameter int AW       = 8,
  parameter int N_WORDS  = 15,
  parameter int IN_BASE  = 30,
  parameter int OUT_BASE = 0
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_req,
  output logic          o_done,
  output logic          o_busy,
  output logic [AW-1:0] o_mem_addr,
  input  logic [7:0]    i_mem_rd_data,
  output logic          o_mem_wr_en,
  output logic [7:0]    o_mem_wr_data,
  output logic [7:0]    o_err_cnt_corr,
  output logic [7:0]    o_err_cnt_dbl
);

  localparam int IDX_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam logic [AW-1:0] IN_B  = AW'(IN_BASE);
  localparam logic [AW-1:0] OUT_B = AW'(OUT_BASE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic [7:0]       r_lsb_in;
  logic [7:0]       r_msb_out;
  logic             r_done;
  logic             r_busy;
  logic             r_wr_en;
  logic [7:0]       r_wr_data;

  logic [15:0]      w_cw;
  logic [10:0]      w_msg;
  logic [1:0]       w_flag;
  logic [AW-1:0]    w_off;
  logic [AW-1:0]    w_addr;

  // In DEC the high byte is arriving on the read port this very cycle.
  assign w_cw = {i_mem_rd_data, r_lsb_in};

  hamming_syndrome u_syndrome (
    .i_cw   (w_cw),
    .o_msg  (w_msg),
    .o_flag (w_flag)
  );

  // Byte offset 2*idx; address sums wrap modulo 2^AW by construction.
  assign w_off = AW'({r_idx, 1'b0});

  always_comb begin
    w_addr = '0;
    case (r_state)
      RD_LO:   w_addr = IN_B + w_off;
      RD_HI:   w_addr = IN_B + w_off + AW'(1);
      WR_LO:   w_addr = OUT_B + w_off;
      WR_HI:   w_addr = OUT_B + w_off + AW'(1);
      default: w_addr = '0;
    endcase
  end

  // Outputs are registered alongside the state so that write strobe/data,
  // busy and done line up with the state they belong to.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_lsb_in  <= 8'h00;
      r_msb_out <= 8'h00;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wr_data <= 8'h00;
    end else begin
      r_wr_en   <= 1'b0;
      r_wr_data <= 8'h00;
      case (r_state)
        IDLE: begin
          if (i_req) begin
            r_state <= RD_LO;
            r_idx   <= '0;
            r_busy  <= 1'b1;
          end
        end
        RD_LO: begin
          r_state <= RD_HI;
        end
        RD_HI: begin
          r_lsb_in <= i_mem_rd_data;
          r_state  <= DEC;
        end
        DEC: begin
          r_msb_out <= {w_flag, 3'b000, w_msg[10:8]};
          r_wr_en   <= 1'b1;
          r_wr_data <= w_msg[7:0];
          r_state   <= WR_LO;
        end
        WR_LO: begin
          r_wr_en   <= 1'b1;
          r_wr_data <= r_msb_out;
          r_state   <= WR_HI;
        end
        WR_HI: begin
          if (r_idx == LAST_IDX) begin
            r_state <= DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_idx   <= r_idx + IDX_W'(1);
            r_state <= RD_LO;
          end
        end
        DONE: begin
          if (!i_req) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_done        = r_done;
  assign o_busy        = r_busy;
  assign o_mem_addr    = w_addr;
  assign o_mem_wr_en   = r_wr_en;
  assign o_mem_wr_data = r_wr_data;

`ifdef HAMMING_STATS_EN
  logic [7:0] r_cnt_corr;
  logic [7:0] r_cnt_dbl;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt_corr <= 8'h00;
      r_cnt_dbl  <= 8'h00;
    end else if (r_state == IDLE && i_req) begin
      r_cnt_corr <= 8'h00;
      r_cnt_dbl  <= 8'h00;
    end else if (r_state == DEC) begin
      if (w_flag == FLAG_COR) begin
        r_cnt_corr <= sat_inc8(r_cnt_corr);
      end
      if (w_flag == FLAG_DBL) begin
        r_cnt_dbl <= sat_inc8(r_cnt_dbl);
      end
    end
  end

  assign o_err_cnt_corr = r_cnt_corr;
  assign o_err_cnt_dbl  = r_cnt_dbl;
`else
  assign o_err_cnt_corr = 8'h00;
  assign o_err_cnt_dbl  = 8'h00;
`endif

endmodule

// File: tb/tb_hamming_dec_engine.sv
// -----------------------------------------------------------------------------
// tb_hamming_dec_engine
//   Self-checking bench for hamming_dec_engine. A byte memory model serves the
//   engine's port; the reference decoder works by brute force over the code:
//   a word is valid if re-encoding its message reproduces it, a single error is
//   found by searching all one-bit neighbours for a valid word.
// -----------------------------------------------------------------------------
module tb_hamming_dec_engine;

  localparam int N     = 15;
  localparam int IN_B  = 30;
  localparam int OUT_B = 0;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req;
  logic       done;
  logic       busy;
  logic [7:0] mem_addr;
  logic [7:0] mem_rd_data;
  logic       mem_wr_en;
  logic [7:0] mem_wr_data;
  logic [7:0] cnt_corr;
  logic [7:0] cnt_dbl;

  always #5 clk = ~clk;

  hamming_dec_engine #(
    .AW(8), .N_WORDS(N), .IN_BASE(IN_B), .OUT_BASE(OUT_B)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_req          (req),
    .o_done         (done),
    .o_busy         (busy),
    .o_mem_addr     (mem_addr),
    .i_mem_rd_data  (mem_rd_data),
    .o_mem_wr_en    (mem_wr_en),
    .o_mem_wr_data  (mem_wr_data),
    .o_err_cnt_corr (cnt_corr),
    .o_err_cnt_dbl  (cnt_dbl)
  );

  logic [7:0] mem  [256];
  logic [7:0] snap [256];
  logic [7:0] exp_lsb [N];
  logic [7:0] exp_msb [N];
  logic [1:0] exp_flag [N];
  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  int wr_outside = 0;

  // Memory model: registered read, write on the strobe.
  always @(posedge clk) begin
    mem_rd_data <= mem[mem_addr];
    if (mem_wr_en) begin
      mem[mem_addr] <= mem_wr_data;
      wr_count <= wr_count + 1;
      if (int'(mem_addr) < OUT_B || int'(mem_addr) >= OUT_B + 2 * N) begin
        wr_outside <= wr_outside + 1;
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [10:0] extract(input logic [15:0] c);
    int pos [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};
    logic [10:0] m;
    for (int i = 0; i < 11; i++) m[i] = c[pos[i]];
    return m;
  endfunction

  function automatic logic [15:0] enc(input logic [10:0] m);
    int pos [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};
    logic [15:0] c;
    logic p;
    c = '0;
    for (int i = 0; i < 11; i++) c[pos[i]] = m[i];
    for (int j = 0; j < 4; j++) begin
      p = 1'b0;
      for (int k = 1; k < 16; k++) if (((k >> j) & 1) == 1) p = p ^ c[k];
      c[1 << j] = p;
    end
    c[0] = ^c[15:1];
    return c;
  endfunction

  task automatic model_decode(input logic [15:0] cw, output logic [10:0] m,
                              output logic [1:0] f);
    logic [15:0] t;
    logic [15:0] one;
    bit found;
    one = 16'h0001;
    found = 1'b0;
    m = extract(cw);
    f = 2'd0;
    if (enc(extract(cw)) != cw) begin
      for (int b = 0; b < 16; b++) begin
        t = cw ^ (one << b);
        if (!found && enc(extract(t)) == t) begin
          found = 1'b1;
          m = extract(t);
        end
      end
      f = found ? 2'd1 : 2'd2;
    end
  endtask

  function automatic int stat_exp(input int c);
`ifdef HAMMING_STATS_EN
    return c;
`else
    return c * 0;
`endif
  endfunction

  task automatic prepare_job(input bit directed);
    logic [15:0] dir [5] = '{16'h0000, 16'hFFFF, 16'hFFDF, 16'hFFFE, 16'hFF9F};
    logic [15:0] cw;
    logic [15:0] one;
    logic [10:0] m;
    logic [1:0]  f;
    int kind, b1, b2;
    one = 16'h0001;
    for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
    for (int i = 0; i < N; i++) begin
      if (directed && i < 5) begin
        cw = dir[i];
      end else begin
        cw   = enc(11'($urandom_range(0, 2047)));
        kind = $urandom_range(0, 2);
        b1   = $urandom_range(0, 15);
        b2   = (b1 + $urandom_range(1, 15)) % 16;
        if (kind >= 1) cw = cw ^ (one << b1);
        if (kind == 2) cw = cw ^ (one << b2);
      end
      mem[IN_B + 2 * i]     = cw[7:0];
      mem[IN_B + 2 * i + 1] = cw[15:8];
      model_decode(cw, m, f);
      exp_lsb[i]  = m[7:0];
      exp_msb[i]  = {f, 3'b000, m[10:8]};
      exp_flag[i] = f;
    end
    for (int a = 0; a < 256; a++) snap[a] = mem[a];
  endtask

  // Runs one job from IDLE (called #1 after a rising edge) and verifies it.
  task automatic run_job_and_verify(input string tag, input bit glitch);
    int n, c_cor, c_dbl, w;
    bit done_seen;
    wr_count = 0;
    wr_outside = 0;
    req = 1'b1;
    @(posedge clk);
    n = 0;
    done_seen = 1'b0;
    while (!done_seen && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL %s busy_after_start: got %b want 1", tag, busy);
        end
      end
      if (glitch && n == 20) req = 1'b0;
      if (glitch && n == 30) req = 1'b1;
      if (n >= 3 && (n - 3) % 5 == 0 && (n - 3) / 5 < N) begin
        w = (n - 3) / 5;
        c_cor = 0;
        c_dbl = 0;
        for (int i = 0; i <= w; i++) begin
          if (exp_flag[i] == 2'd1) c_cor++;
          if (exp_flag[i] == 2'd2) c_dbl++;
        end
        checks++;
        if (cnt_corr !== 8'(stat_exp(c_cor)) || cnt_dbl !== 8'(stat_exp(c_dbl))) begin
          errors++;
          $display("FAIL %s counters_word%0d: got corr=%0d dbl=%0d want corr=%0d dbl=%0d",
                   tag, w, cnt_corr, cnt_dbl, stat_exp(c_cor), stat_exp(c_dbl));
        end
      end
      if (done === 1'b1) done_seen = 1'b1;
    end
    checks++;
    if (!done_seen || n != 5 * N) begin
      errors++;
      $display("FAIL %s done_latency: got %0d edges (seen=%0d) want %0d", tag, n, done_seen, 5 * N);
    end
    for (int a = 0; a < 256; a++) begin
      logic [7:0] want;
      if (a >= OUT_B && a < OUT_B + 2 * N)
        want = ((a - OUT_B) % 2 == 0) ? exp_lsb[(a - OUT_B) / 2] : exp_msb[(a - OUT_B) / 2];
      else
        want = snap[a];
      checks++;
      if (mem[a] !== want) begin
        errors++;
        $display("FAIL %s mem[%0d]: got %02h want %02h", tag, a, mem[a], want);
      end
    end
    checks++;
    if (wr_count != 2 * N || wr_outside != 0) begin
      errors++;
      $display("FAIL %s write_count: got %0d (outside %0d) want %0d (outside 0)",
               tag, wr_count, wr_outside, 2 * N);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_in_done: got %b want 0", tag, busy);
    end
    $display("job %s: done after %0d edges, corr=%0d dbl=%0d", tag, n, cnt_corr, cnt_dbl);
    repeat (2) begin
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b1) begin
        errors++;
        $display("FAIL %s done_hold: got %b want 1", tag, done);
      end
    end
    req = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s done_release: got done=%b busy=%b want 0 0", tag, done, busy);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    req   = 1'b0;
    #12;
    checks++;
    if ({done, busy, mem_wr_en, mem_addr, mem_wr_data, cnt_corr, cnt_dbl} !== '0) begin
      errors++;
      $display("FAIL reset_state: got done=%b busy=%b we=%b addr=%02h wd=%02h corr=%02h dbl=%02h want all 0",
               done, busy, mem_wr_en, mem_addr, mem_wr_data, cnt_corr, cnt_dbl);
    end
    $display("reset: done=%b busy=%b addr=%02h", done, busy, mem_addr);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_full_job();
    logic [7:0] spec_bytes [10] = '{8'h00, 8'h00, 8'hFF, 8'h07, 8'hFF, 8'h47,
                                    8'hFF, 8'h47, 8'hF9, 8'h87};
    prepare_job(1'b1);
    run_job_and_verify("full_job", 1'b0);
    for (int a = 0; a < 10; a++) begin
      checks++;
      if (mem[OUT_B + a] !== spec_bytes[a]) begin
        errors++;
        $display("FAIL directed_byte%0d: got %02h want %02h", a, mem[OUT_B + a], spec_bytes[a]);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int j = 0; j < 2; j++) begin
      prepare_job(1'b0);
      run_job_and_verify((j == 0) ? "b2b_a_glitch" : "b2b_b", (j == 0));
    end
  endtask

  task automatic test_midjob_reset();
    prepare_job(1'b0);
    req = 1'b1;
    @(posedge clk);
    repeat (12) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL midjob_busy_before_reset: got %b want 1", busy);
    end
    rst_n = 1'b0;
    req   = 1'b0;
    #1;
    checks++;
    if ({done, busy, mem_wr_en, mem_addr, mem_wr_data, cnt_corr, cnt_dbl} !== '0) begin
      errors++;
      $display("FAIL midjob_reset_outputs: got done=%b busy=%b we=%b addr=%02h wd=%02h corr=%02h dbl=%02h want all 0",
               done, busy, mem_wr_en, mem_addr, mem_wr_data, cnt_corr, cnt_dbl);
    end
    $display("midjob reset: outputs cleared busy=%b", busy);
    #2;
    rst_n = 1'b1;
    // Mark the output region so the restarted job must rewrite every byte.
    for (int a = OUT_B; a < OUT_B + 2 * N; a++) begin
      mem[a]  = 8'h5A;
      snap[a] = 8'h5A;
    end
    @(posedge clk);
    #1;
    run_job_and_verify("after_reset", 1'b0);
  endtask

  initial begin
    test_reset();
    test_full_job();
    test_back_to_back();
    test_midjob_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute guard in case the design never reaches the expected states.
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
